// File: rtl/btn_reset_pkg.sv
// Shared definitions for the button/reset conditioner: FSM encoding and
// default timing parameters.
package btn_reset_pkg;

    localparam int DEBOUNCE_CYCLES_DEF   = 65535;
    localparam int RESET_HOLD_CYCLES_DEF = 16;
    localparam int STEP_LOW_CYCLES_DEF   = 4;

    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_RUN      = 3'd1,
        S_HOLD     = 3'd2,
        S_WAIT_REL = 3'd3,
        S_STEP_LOW = 3'd4
    } state_e;

endpackage

// File: rtl/btn_reset_ctrl_if.sv
// Board-facing signal bundle: raw buttons in, CPU reset/clock control and
// conditioned button status out.
interface btn_reset_ctrl_if;

    logic btn1;
    logic btn2;
    logic cpu_reset;
    logic step_mode;
    logic step_clk;
    logic btn1_db;
    logic btn2_db;
    logic btn1_press;
    logic btn2_press;

    // Controller side
    modport master (
        input  btn1, btn2,
        output cpu_reset, step_mode, step_clk,
        output btn1_db, btn2_db, btn1_press, btn2_press
    );

    // Board / consumer side
    modport slave (
        output btn1, btn2,
        input  cpu_reset, step_mode, step_clk,
        input  btn1_db, btn2_db, btn1_press, btn2_press
    );

endinterface

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, stability counter, debounced level and a
// one-cycle pulse on each debounced press (1->0).
module btn_debounce
    import btn_reset_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic db_o,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;
    logic          press_q, press_d;

    // Count consecutive cycles where the synchronised level differs from db;
    // any return to the db level restarts the count.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync_q[1] != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = db_q & ~db_d;
    end

    // Synchroniser, counter, debounced level and press pulse registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            db_q    <= 1'b1;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            press_q <= press_d;
        end
    end

    assign db_o    = db_q;
    assign press_o = press_q;

endmodule

// File: rtl/btn_reset_ctrl.sv
// CPU reset sequencer and free-run / single-step clock mode controller,
// driven by two debounced active-low buttons.
module btn_reset_ctrl
    import btn_reset_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
    parameter int RESET_HOLD_CYCLES = RESET_HOLD_CYCLES_DEF,
    parameter int STEP_LOW_CYCLES   = STEP_LOW_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    btn_reset_ctrl_if.master bus
);

    // One down-counter serves both the reset hold and the step-low phase.
    localparam int TMAX = (RESET_HOLD_CYCLES > STEP_LOW_CYCLES) ? RESET_HOLD_CYCLES : STEP_LOW_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] HOLD_LOAD = TW'(RESET_HOLD_CYCLES - 1);
    localparam logic [TW-1:0] STEP_LOAD = TW'(STEP_LOW_CYCLES - 1);

    logic [1:0] btn_raw;
    logic [1:0] db;
    logic [1:0] press;

    assign btn_raw = {bus.btn2, bus.btn1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk     (clk),
                .reset   (reset),
                .btn_i   (btn_raw[gi]),
                .db_o    (db[gi]),
                .press_o (press[gi])
            );
        end
    endgenerate

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          step_mode_q, step_mode_d;
    logic          step_clk_q, step_clk_d;
    logic          cpu_reset_q, cpu_reset_d;

    // Next-state logic; btn1 has priority over btn2 when both pulse together.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        step_mode_d = step_mode_q;
        step_clk_d  = step_clk_q;
        case (state_q)
            S_INIT: begin
                state_d = S_HOLD;
                timer_d = HOLD_LOAD;
            end
            S_RUN: begin
                if (press[0]) begin
                    step_mode_d = 1'b0;
                    step_clk_d  = 1'b1;
                    state_d     = S_HOLD;
                    timer_d     = HOLD_LOAD;
                end else if (press[1]) begin
                    if (!step_mode_q) begin
                        step_mode_d = 1'b1;
                        step_clk_d  = 1'b1;
                        state_d     = S_HOLD;
                        timer_d     = HOLD_LOAD;
                    end else begin
                        step_clk_d = 1'b0;
                        state_d    = S_STEP_LOW;
                        timer_d    = STEP_LOAD;
                    end
                end
            end
            S_HOLD: begin
                if (timer_q == '0) begin
                    state_d = S_WAIT_REL;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_WAIT_REL: begin
                if (db[0] && db[1]) begin
                    state_d = S_RUN;
                end
            end
            S_STEP_LOW: begin
                if (timer_q == '0) begin
                    step_clk_d = 1'b1;
                    state_d    = S_WAIT_REL;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
        // Registered so cpu_reset is glitch-free and tracks the state it enters.
        cpu_reset_d = !((state_d == S_INIT) || (state_d == S_HOLD));
    end

    // State, timer and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_INIT;
            timer_q     <= '0;
            step_mode_q <= 1'b0;
            step_clk_q  <= 1'b1;
            cpu_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            step_mode_q <= step_mode_d;
            step_clk_q  <= step_clk_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end

    assign bus.cpu_reset  = cpu_reset_q;
    assign bus.step_mode  = step_mode_q;
    assign bus.step_clk   = step_clk_q;
    assign bus.btn1_db    = db[0];
    assign bus.btn2_db    = db[1];
    assign bus.btn1_press = press[0];
    assign bus.btn2_press = press[1];

endmodule

// File: tb/tb_btn_reset_ctrl.sv
// Directed scenarios plus randomized button activity, checked every cycle
// against a timestamp-style reference model of the conditioner.
module tb_btn_reset_ctrl;

    localparam int DB   = 8;
    localparam int HOLD = 4;
    localparam int STEP = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    btn_reset_ctrl_if bus();

    btn_reset_ctrl #(
        .DEBOUNCE_CYCLES   (DB),
        .RESET_HOLD_CYCLES (HOLD),
        .STEP_LOW_CYCLES   (STEP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit [1:0] raw_q[$];      // raw button samples, one per clock edge
    bit       m_init;        // no edge seen since reset release
    int       hold_left;     // remaining cycles of CPU reset
    int       step_left;     // remaining cycles of step_clk low
    bit       wait_rel;      // waiting for both buttons released
    bit       m_step_mode;
    bit [1:0] m_db;
    bit [1:0] m_press;
    int       m_run[2];      // consecutive cycles sync differed from db

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        raw_q = {};
        raw_q.push_back(2'b11);
        raw_q.push_back(2'b11);
        m_init      = 1'b1;
        hold_left   = 0;
        step_left   = 0;
        wait_rel    = 1'b0;
        m_step_mode = 1'b0;
        m_db        = 2'b11;
        m_press     = 2'b00;
        m_run[0]    = 0;
        m_run[1]    = 0;
    endfunction

    // Advance the model by one clock edge where 'raw' was sampled.
    function automatic void model_edge(input bit [1:0] raw);
        bit [1:0] sync_b;
        sync_b = raw_q[raw_q.size()-2];
        if (m_init) begin
            m_init    = 1'b0;
            hold_left = HOLD;
        end else if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) wait_rel = 1'b1;
        end else if (step_left > 0) begin
            step_left--;
            if (step_left == 0) wait_rel = 1'b1;
        end else if (wait_rel) begin
            if (m_db == 2'b11) wait_rel = 1'b0;
        end else if (m_press[0]) begin
            m_step_mode = 1'b0;
            hold_left   = HOLD;
        end else if (m_press[1]) begin
            if (!m_step_mode) begin
                m_step_mode = 1'b1;
                hold_left   = HOLD;
            end else begin
                step_left = STEP;
            end
        end
        for (int b = 0; b < 2; b++) begin
            m_press[b] = 1'b0;
            if (sync_b[b] != m_db[b]) begin
                m_run[b]++;
                if (m_run[b] == DB) begin
                    m_db[b]    = sync_b[b];
                    m_run[b]   = 0;
                    m_press[b] = !sync_b[b];
                end
            end else begin
                m_run[b] = 0;
            end
        end
        raw_q.push_back(raw);
        if (raw_q.size() > 4) void'(raw_q.pop_front());
    endfunction

    task automatic check_outputs();
        chk("cpu_reset",  bus.cpu_reset,  32'(!m_init && hold_left == 0));
        chk("step_mode",  bus.step_mode,  32'(m_step_mode));
        chk("step_clk",   bus.step_clk,   32'(step_left == 0));
        chk("btn1_db",    bus.btn1_db,    32'(m_db[0]));
        chk("btn2_db",    bus.btn2_db,    32'(m_db[1]));
        chk("btn1_press", bus.btn1_press, 32'(m_press[0]));
        chk("btn2_press", bus.btn2_press, 32'(m_press[1]));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cpu_reset"},  bus.cpu_reset,  32'd0);
        chk({tag, "_step_mode"},  bus.step_mode,  32'd0);
        chk({tag, "_step_clk"},   bus.step_clk,   32'd1);
        chk({tag, "_btn1_db"},    bus.btn1_db,    32'd1);
        chk({tag, "_btn2_db"},    bus.btn2_db,    32'd1);
        chk({tag, "_btn1_press"}, bus.btn1_press, 32'd0);
        chk({tag, "_btn2_press"}, bus.btn2_press, 32'd0);
    endtask

    // Drive buttons between edges, clock once, then compare after the edge.
    task automatic tick(input bit [1:0] raw);
        bus.btn1 = raw[0];
        bus.btn2 = raw[1];
        @(posedge clk);
        #1;
        model_edge(raw);
        check_outputs();
    endtask

    task automatic hold_btns(input bit [1:0] raw, input int n, input string tag);
        repeat (n) tick(raw);
        $display("%-12s btn2:btn1=%b cycles=%0d cpu_reset=%b step_mode=%b step_clk=%b",
                 tag, raw, n, bus.cpu_reset, bus.step_mode, bus.step_clk);
    endtask

    // Called just after a tick: drops reset mid-cycle and checks outputs
    // before the next rising edge.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values(tag);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        $display("%-12s async reset applied and released", tag);
    endtask

    initial begin
        bit       found;
        bit [1:0] raw;
        int       len;

        bus.btn1 = 1'b1;
        bus.btn2 = 1'b1;
        model_reset();

        // Power-on reset
        repeat (3) begin
            @(posedge clk);
            #1;
            check_reset_values("por");
        end
        @(negedge clk);
        reset = 1'b1;
        hold_btns(2'b11, 12, "power_on");

        // Glitch then a real btn1 press
        hold_btns(2'b10, 5,  "glitch1");
        hold_btns(2'b11, 12, "idle");
        hold_btns(2'b10, 20, "press1");
        hold_btns(2'b11, 20, "release1");

        // Enter step mode, then take one manual step
        hold_btns(2'b01, 20, "press2_mode");
        hold_btns(2'b11, 20, "release2");
        hold_btns(2'b01, 20, "press2_step");
        hold_btns(2'b11, 20, "release2");

        // Back to free-run
        hold_btns(2'b10, 20, "press1_free");
        hold_btns(2'b11, 20, "release1");

        // Simultaneous presses
        hold_btns(2'b00, 20, "press_both");
        hold_btns(2'b11, 20, "release_both");

        // Async reset in the middle of a reset hold
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(2'b10);
            if (!m_init && hold_left > 0 && hold_left < HOLD) found = 1'b1;
        end
        chk("reach_hold", 32'(found), 32'd1);
        if (found) async_reset("mid_hold");
        hold_btns(2'b11, 20, "recover");

        // Async reset in the middle of a step-low phase
        hold_btns(2'b01, 20, "press2_mode");
        hold_btns(2'b11, 20, "release2");
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(2'b01);
            if (step_left > 0) found = 1'b1;
        end
        chk("reach_step", 32'(found), 32'd1);
        if (found) async_reset("mid_step");
        hold_btns(2'b11, 20, "recover");

        // Randomized button activity with occasional async resets
        for (int s = 0; s < 150; s++) begin
            raw = 2'($urandom_range(0, 3));
            len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : $urandom_range(8, 30);
            hold_btns(raw, len, "random");
            if ($urandom_range(0, 19) == 0 && (hold_left > 0 || step_left > 0)) async_reset("rand_async");
        end
        hold_btns(2'b11, 30, "final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
